// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide unit controller with HI/LO registers and pipeline stall
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   E-stage MD instruction valid this cycle
//   MDOp      in   3b: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   A, B      in   32b forwarded rs / rt operands
//   isMD_D    in   D-stage instruction is MD-class
//   busy      out  mult/div in progress
//   stall_MD  out  freeze F/D and bubble E
//   HI, LO    out  32b architectural HI/LO registers
//   done      out  one-cycle pulse after a mult/div commits

module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        isMD_D,
    output logic        busy,
    output logic        stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        done
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] pend_hi, pend_hi_nx;
    logic [31:0] pend_lo, pend_lo_nx;
    logic        pend_wr, pend_wr_nx;   // 0 for a divide by zero: HI/LO must stay as they are
    logic [31:0] hi_nx, lo_nx;
    logic        done_nx;

    // mult/div class is exactly MDOp[2]==0
    logic        is_long_op;
    assign is_long_op = ~MDOp[2];

    // ---------------- arithmetic ----------------
    logic [63:0] prod_s, prod_u;
    assign prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide done on magnitudes so that truncation toward zero and the
    // remainder-takes-sign-of-A rule fall out directly, including -2^31 / -1.
    logic        div_signed, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign div_signed = (MDOp == OP_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign a_mag      = a_neg ? (~A + 32'd1) : A;
    assign b_mag      = b_neg ? (~B + 32'd1) : B;
    assign b_zero     = (B == 32'd0);
    assign q_mag      = b_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag      = b_zero ? 32'd0 : (a_mag % b_mag);
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_hi <= pend_hi_nx;
            pend_lo <= pend_lo_nx;
            pend_wr <= pend_wr_nx;
            HI      <= hi_nx;
            LO      <= lo_nx;
            done    <= done_nx;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_hi_nx = pend_hi;
        pend_lo_nx = pend_lo;
        pend_wr_nx = pend_wr;
        hi_nx      = HI;
        lo_nx      = LO;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (MDOp)
                        OP_MULT: begin
                            state_nx   = BUSY;
                            cnt_nx     = MULT_N;
                            pend_hi_nx = prod_s[63:32];
                            pend_lo_nx = prod_s[31:0];
                            pend_wr_nx = 1'b1;
                        end
                        OP_MULTU: begin
                            state_nx   = BUSY;
                            cnt_nx     = MULT_N;
                            pend_hi_nx = prod_u[63:32];
                            pend_lo_nx = prod_u[31:0];
                            pend_wr_nx = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nx   = BUSY;
                            cnt_nx     = DIV_N;
                            pend_hi_nx = rem;
                            pend_lo_nx = quot;
                            pend_wr_nx = ~b_zero;
                        end
                        OP_MTHI: hi_nx = A;
                        OP_MTLO: lo_nx = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // start is ignored here, including on the completion edge
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                    done_nx  = 1'b1;
                    if (pend_wr) begin
                        hi_nx = pend_hi;
                        lo_nx = pend_lo;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy     = (state == BUSY);
    assign stall_MD = isMD_D & (busy | (start & is_long_op));

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - scoreboard testbench for md_ctrl with a transaction-level HI/LO model

module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        isMD_D;
    logic        busy, stall_MD, done;
    logic [31:0] HI, LO;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDOp     (MDOp),
        .A        (A),
        .B        (B),
        .isMD_D   (isMD_D),
        .busy     (busy),
        .stall_MD (stall_MD),
        .HI       (HI),
        .LO       (LO),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];          // {HI,LO} expected at each done pulse
    logic [31:0] hi_m, lo_m;        // architectural model
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the operands.
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi_in, input logic [31:0] lo_in,
                                   output logic [31:0] hi_o, output logic [31:0] lo_o);
        int ia, ib;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] t, u;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        hi_o = hi_in; lo_o = lo_in;
        case (op)
            3'd0: begin t = sa * sb; hi_o = t[63:32]; lo_o = t[31:0]; end
            3'd1: begin t = ua * ub; hi_o = t[63:32]; lo_o = t[31:0]; end
            3'd2: if (b != 0) begin t = sa / sb; u = sa % sb; lo_o = t[31:0]; hi_o = u[31:0]; end
            3'd3: if (b != 0) begin t = ua / ub; u = ua % ub; lo_o = t[31:0]; hi_o = u[31:0]; end
            3'd4: hi_o = a;
            3'd5: lo_o = a;
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("done_hi", 64'(HI), 64'(mon_e[63:32]));
                check("done_lo", 64'(LO), 64'(mon_e[31:0]));
            end
        end
    end

    // Issue one op; called just after a rising edge. poke: 0 none,
    // 1 mtlo 9 mid-run, 2 new mult on the completion cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic md_d, input int poke);
        logic [31:0] eh, el;
        int n, cycles;
        ref_md(op, a, b, hi_m, lo_m, eh, el);
        start = 1'b1; MDOp = op; A = a; B = b; isMD_D = md_d;
        #1;
        check("stall_at_start", 64'(stall_MD), 64'(md_d && (op < 3'd4)));
        @(posedge clk); #1;
        start = 1'b0;
        if (op < 3'd4) begin
            exp_q.push_back({eh, el});
            n = (op < 3'd2) ? MULT_N : DIV_N;
            cycles = 0;
            while (busy && cycles < 40) begin
                check("stall_busy", 64'(stall_MD), 64'(md_d));
                start = 1'b0;
                if (poke == 1 && cycles == 1) begin
                    start = 1'b1; MDOp = 3'b101; A = 32'd9;
                end
                if (poke == 2 && cycles == n - 1) begin
                    start = 1'b1; MDOp = 3'b000; A = $urandom; B = $urandom;
                end
                @(posedge clk); #1;
                cycles++;
            end
            start = 1'b0;
            check("busy_cycles", 64'(cycles), 64'(n));
            check("busy_after", 64'(busy), 64'd0);
            hi_m = eh; lo_m = el;
            check("hi_after", 64'(HI), 64'(hi_m));
            check("lo_after", 64'(LO), 64'(lo_m));
        end else begin
            hi_m = eh; lo_m = el;
            check("mt_hi", 64'(HI), 64'(hi_m));
            check("mt_lo", 64'(LO), 64'(lo_m));
            check("mt_busy", 64'(busy), 64'd0);
            check("mt_done", 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; MDOp = 3'd0; A = 0; B = 0; isMD_D = 1'b1;
        hi_m = 0; lo_m = 0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_stall", 64'(stall_MD), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // signed mult
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
        check("smult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        check("smult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFA);
        // divu then div
        run_op(3'd3, 32'd7, 32'd2, 1'b1, 0);
        check("divu_lo", 64'(LO), 64'd3);
        check("divu_hi", 64'(HI), 64'd1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        check("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        check("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        // no stall without MD in D
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        // divide by zero keeps HI/LO
        run_op(3'd4, 32'd5, 32'd0, 1'b1, 0);
        run_op(3'd5, 32'd6, 32'd0, 1'b1, 0);
        run_op(3'd2, 32'd1234, 32'd0, 1'b1, 0);
        check("dz_hi", 64'(HI), 64'd5);
        check("dz_lo", 64'(LO), 64'd6);
        // mtlo ignored during busy, taken in idle
        run_op(3'd0, 32'd11, 32'd13, 1'b1, 1);
        check("ign_lo", 64'(LO), 64'd143);
        run_op(3'd5, 32'd9, 32'd0, 1'b0, 0);
        check("idle_mtlo", 64'(LO), 64'd9);
        // new mult on completion edge is not accepted
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
        // no-ops
        run_op(3'd6, $urandom, $urandom, 1'b1, 0);
        run_op(3'd7, $urandom, $urandom, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // reset in the middle of a div
        start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7; isMD_D = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(HI), 64'd0);
        check("arst_lo", 64'(LO), 64'd0);
        check("arst_stall", 64'(stall_MD), 64'd0);
        hi_m = 0; lo_m = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_hi", 64'(HI), 64'd0);
        check("post_rst_lo", 64'(LO), 64'd0);
        run_op(3'd0, 32'd3, 32'hFFFF_FFFB, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
